// File: rtl/time_set.sv
// ============================================================================
// Module   : time_set
// Purpose  : Key debounce and preset-time entry (hours/minutes/seconds/stop).
//            Optional auto-repeat on h/m/s keys: TIME_SET_AUTO_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_set #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_DLY   = 50000000,
    parameter int REPEAT_PER   = 10000000
) (
    input  logic       clk_50Mhz,
    input  logic       rst_n,
    input  logic       key_h_n,
    input  logic       key_m_n,
    input  logic       key_s_n,
    input  logic       key_stop_n,
    output logic [5:0] hou_temp,
    output logic [5:0] min_temp,
    output logic [5:0] sec_temp,
    output logic       h,
    output logic       m,
    output logic       s,
    output logic       stop_clk
);

    localparam int c_NKEY = 4;
    localparam int c_DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [c_NKEY-1:0] w_key_n;
    logic [c_NKEY-1:0] w_evt;
    logic [2:0]        w_acc;

    assign w_key_n = {key_stop_n, key_s_n, key_m_n, key_h_n};

    if (DEBOUNCE_CYC < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_check
        $error("time_set: DEBOUNCE_CYC, REPEAT_DLY and REPEAT_PER must be >= 1");
    end

    // Key index: 0 = hours, 1 = minutes, 2 = seconds, 3 = stop.
    for (genvar k = 0; k < c_NKEY; k++) begin : g_key
        logic [1:0]        r_sync;
        logic              r_acc;
        logic              r_acc_q;
        logic [c_DB_W-1:0] r_db_cnt;
        logic              w_press;

        always_ff @(posedge clk_50Mhz or negedge rst_n) begin
            if (!rst_n) begin
                r_sync   <= 2'b11;
                r_acc    <= 1'b0;
                r_acc_q  <= 1'b0;
                r_db_cnt <= '0;
            end else begin
                r_sync  <= {r_sync[0], w_key_n[k]};
                r_acc_q <= r_acc;
                // Accept a new level only after DEBOUNCE_CYC consecutive differing cycles.
                if (~r_sync[1] != r_acc) begin
                    if (r_db_cnt == c_DB_W'(DEBOUNCE_CYC - 1)) begin
                        r_acc    <= ~r_acc;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end else begin
                    r_db_cnt <= '0;
                end
            end
        end

        assign w_press = r_acc & ~r_acc_q;

        if (k < 3) begin : g_lvl
            assign w_acc[k] = r_acc;
        end

`ifdef TIME_SET_AUTO_REPEAT_EN
        if (k < 3) begin : g_rep
            localparam int c_REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
            localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

            logic [c_REP_W-1:0] r_rep_cnt;
            logic               r_rep_on;
            logic               w_rep;

            // r_rep_cnt holds cycles elapsed since the last press or repeat event.
            assign w_rep = r_acc & (r_rep_on ? (r_rep_cnt == c_REP_W'(REPEAT_PER))
                                             : (r_rep_cnt == c_REP_W'(REPEAT_DLY)));

            always_ff @(posedge clk_50Mhz or negedge rst_n) begin
                if (!rst_n) begin
                    r_rep_cnt <= '0;
                    r_rep_on  <= 1'b0;
                end else if (!r_acc) begin
                    r_rep_cnt <= '0;
                    r_rep_on  <= 1'b0;
                end else if (w_rep) begin
                    r_rep_cnt <= c_REP_W'(1);
                    r_rep_on  <= 1'b1;
                end else begin
                    r_rep_cnt <= r_rep_cnt + 1'b1;
                end
            end

            assign w_evt[k] = w_press | w_rep;
        end else begin : g_norep
            assign w_evt[k] = w_press;
        end
`else
        assign w_evt[k] = w_press;
`endif
    end

    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            hou_temp <= 6'd12;
            min_temp <= 6'd0;
            sec_temp <= 6'd0;
            stop_clk <= 1'b0;
        end else begin
            if (w_evt[0]) hou_temp <= (hou_temp == 6'd23) ? 6'd0 : hou_temp + 6'd1;
            if (w_evt[1]) min_temp <= (min_temp == 6'd59) ? 6'd0 : min_temp + 6'd1;
            if (w_evt[2]) sec_temp <= (sec_temp == 6'd59) ? 6'd0 : sec_temp + 6'd1;
            if (w_evt[3]) stop_clk <= ~stop_clk;
        end
    end

    assign h = w_acc[0];
    assign m = w_acc[1];
    assign s = w_acc[2];

endmodule

`default_nettype wire

// File: doc/time_set.md
TIME_SET -- requirements
Module: time_set

Interface
Parameters (name, default, meaning):
REQ-001 DEBOUNCE_CYC, 1000000, number of consecutive clk_50Mhz cycles a key must hold a new level before it is accepted (20 ms at 50 MHz).
REQ-002 REPEAT_DLY, 50000000, held-key delay before auto-repeat starts (1 s); used only when TIME_SET_AUTO_REPEAT_EN is defined.
REQ-003 REPEAT_PER, 10000000, auto-repeat period (200 ms); used only when TIME_SET_AUTO_REPEAT_EN is defined.

Ports (name, direction, width, meaning):
REQ-004 clk_50Mhz  input  1  the single system clock, 50 MHz, all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 key_h_n, key_m_n, key_s_n, key_stop_n  input  1 each  raw mechanical keys, active-low, asynchronous to clk_50Mhz.
REQ-007 hou_temp, min_temp, sec_temp  output  6 each  preset time fed to the clock-running stage; ranges 0..23, 0..59, 0..59.
REQ-008 h, m, s  output  1 each  debounced pressed level of the matching key, high while that key is accepted as held.
REQ-009 stop_clk  output  1  run/stop flag for the clock-running stage; 1 = time frozen.

Function
REQ-010 Each key input SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each key SHALL have an independent debounce counter; whenever the synchronized level differs from the accepted level, the counter increments, and whenever it matches, the counter clears to 0.
REQ-012 The accepted level SHALL flip on the cycle the counter reaches DEBOUNCE_CYC-1, with the counter clearing on that cycle; any glitch shorter than DEBOUNCE_CYC cycles SHALL NOT change the accepted level.
REQ-013 A press event SHALL be a one-cycle internal pulse on the accepted-level transition released->pressed; releases SHALL produce no event.
REQ-014 Press-event latency SHALL be exactly 2 (sync) + DEBOUNCE_CYC cycles after a clean raw falling edge, and h/m/s SHALL rise on that same cycle.
REQ-015 A key_h_n press event SHALL increment hou_temp by 1, wrapping 23->0; key_m_n SHALL increment min_temp, wrapping 59->0; key_s_n SHALL increment sec_temp, wrapping 59->0.
REQ-016 Increments SHALL be registered; the output SHALL update on the cycle after the press event.
REQ-017 Carry SHALL NOT propagate between fields; sec_temp wrapping 59->0 SHALL NOT change min_temp.
REQ-018 Simultaneous press events on several keys in the same cycle SHALL each be applied independently in that cycle.
REQ-019 A key_stop_n press event SHALL toggle stop_clk; key_stop_n SHALL never auto-repeat.
REQ-020 h, m, and s SHALL equal the accepted pressed level (1 = held) with no pulse stretching, so that the 1 Hz downstream sampler sees them for the full hold time.

Reset
REQ-021 While rst_n=0, hou_temp=12, min_temp=0, sec_temp=0, stop_clk=0, h=m=s=0, all debounce and repeat counters are 0, and all accepted levels are "released".
REQ-022 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no increment; after release, a key already held low SHALL be debounced afresh and SHALL generate one press event.

Configuration
REQ-023 With TIME_SET_AUTO_REPEAT_EN defined, an h/m/s key held continuously for REPEAT_DLY cycles after its press event SHALL generate a further press event, then one every REPEAT_PER cycles until release; release SHALL clear that key's repeat counter immediately.
REQ-024 Without TIME_SET_AUTO_REPEAT_EN, no repeat logic SHALL be synthesized, and exactly one increment SHALL occur per press regardless of hold time.

Verification (DEBOUNCE_CYC=4, REPEAT_DLY=20, REPEAT_PER=5 in simulation)
REQ-025 Reset release with keys idle -> hou_temp=12, min_temp=0, sec_temp=0, stop_clk=0, h=m=s=0.
REQ-026 key_m_n low for 2 cycles then high -> min_temp unchanged and m stays 0; key_m_n held low -> m=1 after 6 cycles and min_temp=1 one cycle later.
REQ-027 Press key_s_n 60 times from 0 -> sec_temp ends at 0, min_temp unchanged; press key_h_n 12 times from 12 -> hou_temp=0.
REQ-028 key_h_n and key_s_n fall on the same cycle -> hou_temp and sec_temp increment on the same cycle.
REQ-029 Press key_stop_n twice -> stop_clk goes 0->1->0, hou_temp/min_temp/sec_temp unchanged.
REQ-030 With the macro, hold key_h_n for 40 cycles after its press event -> hou_temp advances 1+1+4=6 times; without the macro, the same stimulus -> advances exactly once.
